// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes and default datapath sizes.
package alu_pkg;

    localparam logic [3:0] AND = 4'b0000;
    localparam logic [3:0] OR  = 4'b0001;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SLT = 4'b0111;
    localparam logic [3:0] NOR = 4'b1100;

    localparam int WIDTH_DEF = 32;
    localparam int RADDR_DEF = 5;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand forwarding select: the EX/MEM producer beats MEM/WB, and r0 is never forwarded.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic [RADDR-1:0] src,
    input  logic [WIDTH-1:0] latched,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    output logic [WIDTH-1:0] fwd
);

    always_comb begin
        fwd = latched;
        if (src != '0) begin
            if (exmem_reg_write && (exmem_rd == src)) begin
                fwd = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == src)) begin
                fwd = memwb_result;
            end
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding onto the ALU operands; supports stall and flush.
module ex_operand_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_alu_src,
    input  logic [3:0]       id_contr,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_result,
    input  logic             stall,
    input  logic             flush,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [WIDTH-1:0] ex_rt_fwd,
    output logic [3:0]       ex_contr,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write
);

    logic             valid_q,     valid_d;
    logic [WIDTH-1:0] rs_val_q,    rs_val_d;
    logic [WIDTH-1:0] rt_val_q,    rt_val_d;
    logic [WIDTH-1:0] imm_q,       imm_d;
    logic             alu_src_q,   alu_src_d;
    logic [3:0]       contr_q,     contr_d;
    logic [RADDR-1:0] rs_q,        rs_d;
    logic [RADDR-1:0] rt_q,        rt_d;
    logic [RADDR-1:0] rd_q,        rd_d;
    logic             reg_write_q, reg_write_d;

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rs (
        .src             (rs_q),
        .latched         (rs_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd             (fwd_rs)
    );

    fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_rt (
        .src             (rt_q),
        .latched         (rt_val_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd             (fwd_rt)
    );

    always_comb begin
        valid_d     = valid_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        alu_src_d   = alu_src_q;
        contr_d     = contr_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        if (flush) begin
            valid_d     = 1'b0;
            rs_val_d    = '0;
            rt_val_d    = '0;
            imm_d       = '0;
            alu_src_d   = 1'b0;
            contr_d     = AND;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
            reg_write_d = 1'b0;
        end else if (stall) begin
            // Re-capture forwarded values so a producer retiring mid-stall is not lost.
            rs_val_d = fwd_rs;
            rt_val_d = fwd_rt;
        end else begin
            valid_d     = id_valid;
            rs_val_d    = id_rs_data;
            rt_val_d    = id_rt_data;
            imm_d       = id_imm;
            alu_src_d   = id_alu_src;
            contr_d     = id_contr;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            reg_write_d = id_reg_write & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            contr_q     <= AND;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            alu_src_q   <= alu_src_d;
            contr_q     <= contr_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_a         = fwd_rs;
    assign ex_rt_fwd    = fwd_rt;
    assign ex_b         = alu_src_q ? imm_q : fwd_rt;
    assign ex_contr     = contr_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, load, forwarding priority, immediate, stall and flush.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src;
    logic [3:0]  id_contr;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall, flush;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_rt_fwd;
    logic [3:0]  ex_contr;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_alu_src      (id_alu_src),
        .id_contr        (id_contr),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .stall           (stall),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_a            (ex_a),
        .ex_b            (ex_b),
        .ex_rt_fwd       (ex_rt_fwd),
        .ex_contr        (ex_contr),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b1; id_rs_data = 32'hDEAD; id_rt_data = 32'hBEEF; id_imm = 32'h1;
        id_alu_src = 1'b0; id_contr = 4'b0110; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        id_reg_write = 1'b1;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'h0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'h0;

        // Reset with a valid instruction presented
        tick();
        check("rst_valid",  32'(ex_valid), 32'h0);
        check("rst_a",      ex_a, 32'h0);
        check("rst_b",      ex_b, 32'h0);
        check("rst_contr",  32'(ex_contr), 32'h0);
        check("rst_rd",     32'(ex_rd), 32'h0);
        check("rst_regwr",  32'(ex_reg_write), 32'h0);

        // Plain load
        rst = 1'b0;
        id_rs_data = 32'd5; id_rt_data = 32'd7; id_contr = 4'b0010; id_alu_src = 1'b0;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd5; id_reg_write = 1'b1;
        tick();
        check("load_a",     ex_a, 32'd5);
        check("load_b",     ex_b, 32'd7);
        check("load_contr", 32'(ex_contr), 32'h2);
        check("load_valid", 32'(ex_valid), 32'h1);
        check("load_rd",    32'(ex_rd), 32'd5);
        check("load_regwr", 32'(ex_reg_write), 32'h1);

        // Forward priority on rs=3
        id_rs = 5'd3; id_rs_data = 32'hAA;
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
        #1;
        check("fwd_exmem_wins", ex_a, 32'h11);
        exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb", ex_a, 32'h22);
        memwb_reg_write = 1'b0;
        #1;
        check("fwd_none", ex_a, 32'hAA);

        // r0 is never forwarded
        id_rs = 5'd0; id_rs_data = 32'h55;
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'h22;
        #1;
        check("fwd_r0", ex_a, 32'h55);

        // Immediate operand with forwarded rt as store data
        id_alu_src = 1'b1; id_imm = 32'hFFFFFFFC; id_rt = 5'd6; id_rt_data = 32'd1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_result = 32'd9;
        memwb_reg_write = 1'b0;
        tick();
        check("imm_b",      ex_b, 32'hFFFFFFFC);
        check("imm_rt_fwd", ex_rt_fwd, 32'd9);

        // reg_write is gated by id_valid
        exmem_reg_write = 1'b0;
        id_valid = 1'b0; id_reg_write = 1'b1; id_alu_src = 1'b0;
        tick();
        check("inv_valid", 32'(ex_valid), 32'h0);
        check("inv_regwr", 32'(ex_reg_write), 32'h0);

        // Stall captures a value forwarded from MEM/WB
        id_valid = 1'b1; id_rs = 5'd4; id_rs_data = 32'h10; id_contr = 4'b0110; id_rd = 5'd7;
        id_rt = 5'd0; id_rt_data = 32'd0;
        tick();
        memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h44;
        #1;
        check("stall_pre_a", ex_a, 32'h44);
        stall = 1'b1;
        id_rs_data = 32'h99; id_contr = 4'b0001; id_rd = 5'd9; id_rs = 5'd8;
        tick();
        memwb_rd = 5'd0; memwb_result = 32'h77;
        #1;
        check("stall1_a", ex_a, 32'h44);
        tick();
        check("stall2_a",     ex_a, 32'h44);
        check("stall2_contr", 32'(ex_contr), 32'h6);
        check("stall2_rd",    32'(ex_rd), 32'd7);
        check("stall2_valid", 32'(ex_valid), 32'h1);

        // Flush wins over a simultaneous stall
        memwb_reg_write = 1'b0;
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(ex_valid), 32'h0);
        check("flush_regwr", 32'(ex_reg_write), 32'h0);
        check("flush_rd",    32'(ex_rd), 32'h0);
        check("flush_a",     ex_a, 32'h0);
        check("flush_contr", 32'(ex_contr), 32'h0);

        // Normal load resumes after the bubble
        flush = 1'b0; stall = 1'b0;
        id_rs = 5'd2; id_rs_data = 32'h33; id_contr = 4'b0000; id_rd = 5'd4; id_reg_write = 1'b1;
        tick();
        check("resume_valid", 32'(ex_valid), 32'h1);
        check("resume_a",     ex_a, 32'h33);
        check("resume_rd",    32'(ex_rd), 32'd4);

        // Reset wins over stall
        stall = 1'b1; rst = 1'b1;
        tick();
        check("rst_stall_valid", 32'(ex_valid), 32'h0);
        check("rst_stall_a",     ex_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
